// File: rtl/bp_be_pkg.sv
// Back-end shared types: integer-op decode and the issue packet carried from
// the arbiter into the integer pipe.
`define BP_BE_ISSUE_PKT_WIDTH ($bits(bp_be_pkg::bp_be_issue_pkt_s))

package bp_be_pkg;

  typedef enum logic [2:0] {
    e_int_add,
    e_int_sub,
    e_int_and,
    e_int_or,
    e_int_xor,
    e_int_slt,
    e_int_beq,
    e_int_bne
  } bp_be_int_op_e;

  typedef struct packed {
    bp_be_int_op_e int_op;
    logic          src2_is_imm;
  } bp_be_decode_s;

  localparam int bp_be_decode_width = $bits(bp_be_decode_s);

  // pc is held at full 64 bits so the packet type stays parameter-free;
  // only the low vaddr_width_p bits are ever meaningful.
  typedef struct packed {
    bp_be_decode_s decode;
    logic [63:0]   pc;
    logic [63:0]   rs1;
    logic [63:0]   rs2;
    logic [63:0]   imm;
    logic          id;
  } bp_be_issue_pkt_s;

endpackage

// File: rtl/bp_be_pipe_int.sv
// Combinational integer ALU / branch resolver fed from the issue register.
module bp_be_pipe_int
  import bp_be_pkg::*;
 #(parameter vaddr_width_p = "inv")
  (input  bp_be_decode_s              decode_i,
   input  logic [63:0]                pc_i,
   input  logic [63:0]                rs1_i,
   input  logic [63:0]                rs2_i,
   input  logic [63:0]                imm_i,
   output logic [63:0]                data_o,
   output logic [vaddr_width_p-1:0]   br_tgt_o,
   output logic                       taken_o);

  logic [63:0] src2;

  always_comb begin
    src2     = decode_i.src2_is_imm ? imm_i : rs2_i;
    data_o   = '0;
    taken_o  = 1'b0;
    br_tgt_o = vaddr_width_p'(pc_i + imm_i);
    case (decode_i.int_op)
      e_int_add: data_o = rs1_i + src2;
      e_int_sub: data_o = rs1_i - src2;
      e_int_and: data_o = rs1_i & src2;
      e_int_or : data_o = rs1_i | src2;
      e_int_xor: data_o = rs1_i ^ src2;
      e_int_slt: data_o = {63'b0, ($signed(rs1_i) < $signed(src2))};
      // Branches always compare the two registers, never the immediate.
      e_int_beq: taken_o = (rs1_i == rs2_i);
      e_int_bne: taken_o = (rs1_i != rs2_i);
      default  : data_o = '0;
    endcase
  end

endmodule

// File: rtl/bp_be_pipe_int_arbiter.sv
// Two-requester round-robin issue arbiter in front of a single integer pipe,
// with an issue register and a result register (transfer to result = 2 cycles).
module bp_be_pipe_int_arbiter
  import bp_be_pkg::*;
 #(parameter vaddr_width_p = "inv")
  (input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic [1:0]                           req_v_i,
   output logic [1:0]                           req_ready_o,
   input  logic [1:0][bp_be_decode_width-1:0]   decode_i,
   input  logic [1:0][vaddr_width_p-1:0]        pc_i,
   input  logic [1:0][63:0]                     rs1_i,
   input  logic [1:0][63:0]                     rs2_i,
   input  logic [1:0][63:0]                     imm_i,
   input  logic                                 stall_i,
   input  logic                                 flush_i,
   output logic                                 result_v_o,
   output logic                                 result_id_o,
   output logic [63:0]                          data_o,
   output logic [vaddr_width_p-1:0]             br_tgt_o,
   output logic                                 taken_o);

  logic             rr_pri_r;   // requester holding priority on a tie
  logic             grant_id;
  logic             xfer;
  bp_be_issue_pkt_s grant_pkt;
  bp_be_issue_pkt_s issue_r;
  logic             issue_v_r;

  logic [63:0]              pipe_data;
  logic [vaddr_width_p-1:0] pipe_br_tgt;
  logic                     pipe_taken;

  always_comb begin
    grant_id    = (req_v_i == 2'b11) ? rr_pri_r : ~req_v_i[0];
    xfer        = (|req_v_i) & ~stall_i & ~flush_i & ~reset_i;
    req_ready_o = '0;
    if (xfer)
      req_ready_o[grant_id] = 1'b1;

    grant_pkt.decode = bp_be_decode_s'(decode_i[grant_id]);
    grant_pkt.pc     = 64'(pc_i[grant_id]);
    grant_pkt.rs1    = rs1_i[grant_id];
    grant_pkt.rs2    = rs2_i[grant_id];
    grant_pkt.imm    = imm_i[grant_id];
    grant_pkt.id     = grant_id;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      rr_pri_r <= 1'b0;
    else if (xfer)
      rr_pri_r <= ~grant_id;
  end

  // Flush outranks stall; a stall freezes the packet, otherwise a missing
  // transfer becomes a bubble.
  always_ff @(posedge clk_i) begin
    if (reset_i | flush_i) begin
      issue_v_r <= 1'b0;
    end else if (!stall_i) begin
      issue_v_r <= xfer;
      if (xfer)
        issue_r <= grant_pkt;
    end
  end

  bp_be_pipe_int #(.vaddr_width_p(vaddr_width_p)) pipe_int
    (.decode_i (issue_r.decode),
     .pc_i     (issue_r.pc),
     .rs1_i    (issue_r.rs1),
     .rs2_i    (issue_r.rs2),
     .imm_i    (issue_r.imm),
     .data_o   (pipe_data),
     .br_tgt_o (pipe_br_tgt),
     .taken_o  (pipe_taken));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      result_v_o  <= 1'b0;
      result_id_o <= 1'b0;
      data_o      <= '0;
      br_tgt_o    <= '0;
      taken_o     <= 1'b0;
    end else if (flush_i) begin
      result_v_o  <= 1'b0;
    end else if (issue_v_r & ~stall_i) begin
      result_v_o  <= 1'b1;
      result_id_o <= issue_r.id;
      data_o      <= pipe_data;
      br_tgt_o    <= pipe_br_tgt;
      taken_o     <= pipe_taken;
    end else begin
      result_v_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bp_be_pipe_int_arbiter.sv
// Randomized bench for bp_be_pipe_int_arbiter against a cycle-level reference model.
module tb_bp_be_pipe_int_arbiter;
  import bp_be_pkg::*;

  localparam int VW = 32;

  logic                               clk;
  logic                               reset_i;
  logic [1:0]                         req_v_i;
  logic [1:0]                         req_ready_o;
  logic [1:0][bp_be_decode_width-1:0] decode_i;
  logic [1:0][VW-1:0]                 pc_i;
  logic [1:0][63:0]                   rs1_i, rs2_i, imm_i;
  logic                               stall_i, flush_i;
  logic                               result_v_o, result_id_o, taken_o;
  logic [63:0]                        data_o;
  logic [VW-1:0]                      br_tgt_o;

  bp_be_pipe_int_arbiter #(.vaddr_width_p(VW)) dut
    (.clk_i(clk), .reset_i(reset_i), .req_v_i(req_v_i), .req_ready_o(req_ready_o),
     .decode_i(decode_i), .pc_i(pc_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
     .stall_i(stall_i), .flush_i(flush_i), .result_v_o(result_v_o),
     .result_id_o(result_id_o), .data_o(data_o), .br_tgt_o(br_tgt_o), .taken_o(taken_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [1:0]  last_rdy;

  // reference model state
  int          m_pri = 0;
  logic        m_iss_v = 0, m_iss_id = 0, m_iss_tk = 0;
  logic [63:0] m_iss_data = '0;
  logic [VW-1:0] m_iss_tgt = '0;
  logic        m_res_v = 0, m_res_id = 0, m_res_tk = 0;
  logic [63:0] m_res_data = '0;
  logic [VW-1:0] m_res_tgt = '0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void ref_exec(input int r, output logic [63:0] data,
                                   output logic [VW-1:0] tgt, output logic tk);
    bp_be_decode_s d;
    logic [63:0]   a, b, op2;
    d    = bp_be_decode_s'(decode_i[r]);
    a    = rs1_i[r];
    b    = rs2_i[r];
    op2  = d.src2_is_imm ? imm_i[r] : b;
    data = '0;
    tk   = 1'b0;
    case (d.int_op)
      e_int_add: data = a + op2;
      e_int_sub: data = a - op2;
      e_int_and: data = a & op2;
      e_int_or : data = a | op2;
      e_int_xor: data = a ^ op2;
      e_int_slt: data = ($signed(a) < $signed(op2)) ? 64'd1 : 64'd0;
      e_int_beq: tk = (a == b);
      e_int_bne: tk = (a != b);
      default  : data = '0;
    endcase
    tgt = VW'(64'(pc_i[r]) + imm_i[r]);
  endfunction

  task automatic set_op(input int r, input bp_be_int_op_e op, input logic use_imm,
                        input logic [VW-1:0] pc, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] imm);
    bp_be_decode_s d;
    d.int_op      = op;
    d.src2_is_imm = use_imm;
    decode_i[r]   = d;
    pc_i[r]       = pc;
    rs1_i[r]      = a;
    rs2_i[r]      = b;
    imm_i[r]      = imm;
  endtask

  task automatic rand_ops();
    logic [63:0] a;
    for (int r = 0; r < 2; r++) begin
      a = {$urandom, $urandom};
      set_op(r, bp_be_int_op_e'(3'($urandom_range(0, 7))), 1'($urandom),
             VW'($urandom), a, ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom},
             {$urandom, $urandom});
    end
  endtask

  // One clock: drive inputs at the falling edge, check ready, then check
  // registered outputs just after the rising edge.
  task automatic cycle(input logic [1:0] v, input logic st, input logic fl, input logic rst);
    int         g;
    logic [1:0] exp_rdy;
    @(negedge clk);
    req_v_i = v; stall_i = st; flush_i = fl; reset_i = rst;
    #1;
    g = -1;
    exp_rdy = 2'b00;
    if (!rst && !st && !fl && v != 2'b00) begin
      if (v == 2'b11) g = m_pri;
      else            g = v[0] ? 0 : 1;
      exp_rdy[g] = 1'b1;
    end
    last_rdy = req_ready_o;
    check("req_ready", req_ready_o, exp_rdy);
    @(posedge clk);
    #1;
    if (rst) begin
      m_pri = 0; m_iss_v = 0; m_res_v = 0; m_res_id = 0;
      m_res_data = '0; m_res_tgt = '0; m_res_tk = 0;
    end else if (fl) begin
      m_iss_v = 0; m_res_v = 0;
    end else if (st) begin
      m_res_v = 0;
    end else begin
      m_res_v = m_iss_v;
      if (m_iss_v) begin
        m_res_id = m_iss_id; m_res_data = m_iss_data;
        m_res_tgt = m_iss_tgt; m_res_tk = m_iss_tk;
      end
      m_iss_v = (g >= 0);
      if (g >= 0) begin
        m_iss_id = 1'(g);
        ref_exec(g, m_iss_data, m_iss_tgt, m_iss_tk);
        m_pri = 1 - g;
      end
    end
    check("result_v",  result_v_o,  m_res_v);
    check("result_id", result_id_o, m_res_id);
    check("data",      data_o,      m_res_data);
    check("br_tgt",    br_tgt_o,    m_res_tgt);
    check("taken",     taken_o,     m_res_tk);
  endtask

  int unsigned cnt;

  initial begin
    reset_i = 1'b1; req_v_i = '0; stall_i = 1'b0; flush_i = 1'b0;
    decode_i = '0; pc_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0;

    cycle(2'b00, 0, 0, 1);
    cycle(2'b11, 0, 0, 1);
    check("reset_result_v", result_v_o, 0);
    check("reset_data", data_o, 0);

    // alternating grants with both requesters valid
    rand_ops();
    for (int i = 0; i < 6; i++) begin
      cycle((i < 4) ? 2'b11 : 2'b00, 0, 0, 0);
      if (i < 4) check("rr_grant", last_rdy, (i % 2 == 1) ? 2 : 1);
      if (i >= 1 && i <= 4) begin
        check("rr_res_v", result_v_o, 1);
        check("rr_res_id", result_id_o, (i - 1) % 2);
      end
    end

    // ADD 5 + 7 from requester 0
    set_op(0, e_int_add, 1'b0, VW'(32'h40), 64'd5, 64'd7, 64'd0);
    cycle(2'b01, 0, 0, 0);
    cycle(2'b00, 0, 0, 0);
    check("add_v", result_v_o, 1);
    check("add_data", data_o, 12);
    check("add_id", result_id_o, 0);

    // BEQ taken from requester 1
    set_op(1, e_int_beq, 1'b0, VW'(32'h100), 64'd3, 64'd3, 64'h20);
    cycle(2'b10, 0, 0, 0);
    cycle(2'b00, 0, 0, 0);
    check("beq_taken", taken_o, 1);
    check("beq_tgt", br_tgt_o, 32'h120);
    check("beq_id", result_id_o, 1);

    // three-cycle stall with an op sitting in issue
    rand_ops();
    cycle(2'b01, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(2'b11, 1, 0, 0);
      check("stall_ready", last_rdy, 0);
      check("stall_res_v", result_v_o, 0);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(2'b00, 0, 0, 0);
      if (i == 0) check("stall_release", result_v_o, 1);
      cnt += result_v_o;
    end
    check("stall_once", cnt, 1);

    // flush with an op in issue and both requesters waiting
    rand_ops();
    cycle(2'b11, 0, 0, 0);
    cycle(2'b11, 0, 1, 0);
    check("flush_ready", last_rdy, 0);
    cnt = result_v_o;
    for (int i = 0; i < 3; i++) begin
      cycle(2'b00, 0, 0, 0);
      cnt += result_v_o;
    end
    check("flush_no_result", cnt, 0);
    cycle(2'b11, 0, 0, 0);
    check("flush_rr_kept", last_rdy, 2'b01);

    // reset in the middle of a stream
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      cycle(2'b11, 0, 0, 0);
    end
    cycle(2'b11, 0, 0, 1);
    check("mid_reset_v", result_v_o, 0);
    check("mid_reset_data", data_o, 0);
    check("mid_reset_tgt", br_tgt_o, 0);
    cycle(2'b11, 0, 0, 0);
    check("post_reset_grant", last_rdy, 2'b01);
    cycle(2'b00, 0, 0, 0);
    cycle(2'b00, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      cycle(2'($urandom), $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_be_pipe_int_arbiter.md
BP_BE_PIPE_INT_ARBITER -- requirements
Module: bp_be_pipe_int_arbiter

Interface
REQ-001 SHALL have parameter vaddr_width_p, default "inv", meaning virtual PC width (must be overridden).
REQ-002 SHALL have port clk_i, input, 1 bit, meaning single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_i, input, 1 bit, meaning reset; synchronous and active-high.
REQ-004 SHALL have ports req_v_i, input, [1:0], meaning per-requester issue valid.
REQ-005 SHALL have ports req_ready_o, output, [1:0], meaning per-requester accept; a transfer occurs when req_v_i[i] & req_ready_o[i].
REQ-006 SHALL have ports decode_i, pc_i, rs1_i, rs2_i, imm_i, input, 2 x (bp_be_decode_width / vaddr_width_p / 64 / 64 / 64), meaning per-requester operands.
REQ-007 SHALL have port stall_i, input, 1 bit, meaning downstream hold of the issue stage.
REQ-008 SHALL have port flush_i, input, 1 bit, meaning kill all in-flight operations.
REQ-009 SHALL have ports result_v_o (1), result_id_o (1), data_o (64), br_tgt_o (vaddr_width_p), taken_o (1), all outputs, meaning registered integer-pipe result and owning requester.

Function
REQ-010 SHALL grant at most one requester per cycle using round-robin: the requester not granted most recently has priority; after reset requester 0 has priority.
REQ-011 SHALL assert req_ready_o[i] only for the granted requester, and only when stall_i=0 and flush_i=0.
REQ-012 SHALL update the round-robin pointer only on an actual transfer; no transfer leaves priority unchanged.
REQ-013 SHALL capture the granted packet (decode, pc, rs1, rs2, imm, id) into an issue register with valid bit on transfer; latency from transfer in cycle N to result_v_o=1 SHALL be exactly 2 cycles (N+2).
REQ-014 SHALL drive the integer pipe combinationally from the issue register and capture its data/br_tgt/taken plus id into a result register when issue valid=1 and stall_i=0.
REQ-015 SHALL hold the issue register unchanged while stall_i=1, with result_v_o=0 in the following cycle.
REQ-016 SHALL clear issue valid and result valid on the edge after flush_i=1; flush_i SHALL take priority over stall_i and any simultaneous request.
REQ-017 SHALL set issue valid=0 when no transfer occurs and stall_i=0 (bubble propagates).
REQ-018 SHALL hold data_o, br_tgt_o, taken_o, result_id_o at last-written values when result_v_o=0; consumers SHALL qualify with result_v_o.
REQ-019 SHALL present back-to-back transfers from either requester at one per cycle with no bubbles when unstalled.

Reset
REQ-020 SHALL on reset_i=1 force issue valid=0, result_v_o=0, result_id_o=0, data_o=0, br_tgt_o=0, taken_o=0, round-robin priority to requester 0.
REQ-021 SHALL hold req_ready_o=0 during any cycle with reset_i=1; reset mid-operation SHALL discard all in-flight operations without producing a result.

Structure
REQ-022 SHALL define the issue-packet struct (decode, pc, rs1, rs2, imm, id) in bp_be_pkg alongside bp_be_decode_s, with a width macro.
REQ-023 SHALL instantiate exactly one bp_be_pipe_int as its sub-module; arbitration and registers SHALL be local.

Verification
REQ-024 SHALL cover: req_v_i=2'b11 held 4 cycles after reset -> grants 0,1,0,1; result_id_o sequence 0,1,0,1 from cycle 2.
REQ-025 SHALL cover: requester 0 ADD rs1=5, rs2=7 accepted cycle N -> result_v_o=1, data_o=12, result_id_o=0 at cycle N+2.
REQ-026 SHALL cover: BEQ rs1=rs2=3, pc=0x100, imm=0x20 -> taken_o=1, br_tgt_o=0x120 two cycles after transfer.
REQ-027 SHALL cover: stall_i=1 for 3 cycles with an op in issue -> req_ready_o=0, result_v_o=0 during stall; result appears 1 cycle after stall drops, exactly once.
REQ-028 SHALL cover: flush_i=1 with ops in both stages and req_v_i=2'b11 -> no result_v_o for either flushed op, no transfer that cycle, round-robin pointer unchanged.
REQ-029 SHALL cover: reset_i=1 asserted mid-stream -> all outputs 0 next cycle; first post-reset grant goes to requester 0.
